router_pkt_receiver: RTL and testbench

//  Downstream stage of router_dut: consumes the dut_outp/outp_valid byte stream, parses each packet
//  (DA, SA, LEN, payload, XOR checksum), buffers payload store-and-forward, releases only packets

---
 rtl/router_pkg.sv | 9 +
 rtl/router_rx_fifo.sv | 38 +++
 rtl/router_pkt_receiver.sv | 155 +++++++++++++++
 tb/tb_router_pkt_receiver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared parser states, status error bit indices and header size.
package router_pkg;
  typedef enum logic [2:0] {IDLE, SA, LEN, PAYLOAD, CSUM, DRAIN} rx_state_e;
  localparam int ERR_CSUM  = 0;
  localparam int ERR_TRUNC = 1;
  localparam int ERR_LEN   = 2;
  localparam int ERR_OVF   = 3;
  localparam int HDR_BYTES = 3;
endpackage

// File: rtl/router_rx_fifo.sv
// router_rx_fifo: store-and-forward FIFO with a tentative write pointer, commit and rollback.
module router_rx_fifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [8:0] wr_data,
  input  logic       commit,
  input  logic       rollback,
  input  logic       rd_en,
  output logic [8:0] rd_data,
  output logic       full,
  output logic       empty_committed
);
  localparam int AW = $clog2(DEPTH);
  logic [8:0]  r_mem [DEPTH];
  logic [AW:0] r_wr, r_cm, r_rd;
  // Reader only sees committed entries; full counts tentative ones too.
  assign full            = (r_wr - r_rd) == (AW + 1)'(DEPTH);
  assign empty_committed = r_cm == r_rd;
  assign rd_data         = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (wr_en && !full) r_mem[r_wr[AW-1:0]] <= wr_data;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr <= '0;
      r_cm <= '0;
      r_rd <= '0;
    end else begin
      if (rollback) r_wr <= r_cm;
      else if (wr_en && !full) r_wr <= r_wr + 1'b1;
      if (commit) r_cm <= r_wr;
      if (rd_en && !empty_committed) r_rd <= r_rd + 1'b1;
    end
  end
endmodule

// File: rtl/router_pkt_receiver.sv
// router_pkt_receiver: parses router packets, checks XOR checksum, forwards good payloads.
module router_pkt_receiver
  import router_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       dut_outp,
  input  logic             outp_valid,
  output logic [7:0]       pkt_data,
  output logic             pkt_valid,
  output logic             pkt_last,
  input  logic             pkt_ready,
  output logic [7:0]       hdr_da,
  output logic [7:0]       hdr_sa,
  output logic [7:0]       hdr_len,
  output logic             status_valid,
  output logic [3:0]       status_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fifo_full
);
  rx_state_e  r_state, w_state_n;
  logic [7:0] r_da, r_sa, r_len, r_cnt, r_csum;
  logic [7:0] w_da_n, w_sa_n, w_len_n, w_cnt_n, w_csum_n, w_x;
  logic       w_wr, w_commit, w_status, w_full, w_empty, w_rd_en;
  logic [3:0] w_err;
  logic [8:0] w_rd_data;
  assign w_x       = r_csum ^ dut_outp;
  assign w_rd_en   = !w_empty && (!pkt_valid || pkt_ready);
  assign fifo_full = w_full;
  router_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk             (clk),
    .reset           (reset),
    .wr_en           (w_wr),
    .wr_data         ({r_cnt == 8'd1, dut_outp}),
    .commit          (w_commit),
    .rollback        (|w_err),
    .rd_en           (w_rd_en),
    .rd_data         (w_rd_data),
    .full            (w_full),
    .empty_committed (w_empty)
  );
  always_comb begin
    w_state_n = r_state;
    w_da_n    = r_da;
    w_sa_n    = r_sa;
    w_len_n   = r_len;
    w_cnt_n   = r_cnt;
    w_csum_n  = r_csum;
    w_wr      = 1'b0;
    w_commit  = 1'b0;
    w_status  = 1'b0;
    w_err     = '0;
    case (r_state)
      IDLE: if (outp_valid) begin
        w_da_n    = dut_outp;
        w_sa_n    = '0;
        w_len_n   = '0;
        w_csum_n  = dut_outp;
        w_state_n = SA;
      end
      SA: if (!outp_valid) begin
        w_status = 1'b1;
        w_err[ERR_TRUNC] = 1'b1;
        w_state_n = IDLE;
      end else begin
        w_sa_n    = dut_outp;
        w_csum_n  = w_x;
        w_state_n = LEN;
      end
      LEN: if (!outp_valid) begin
        w_status = 1'b1;
        w_err[ERR_TRUNC] = 1'b1;
        w_state_n = IDLE;
      end else if (dut_outp == 8'd0) begin
        w_status = 1'b1;
        w_err[ERR_LEN] = 1'b1;
        w_state_n = DRAIN;
      end else begin
        w_len_n   = dut_outp;
        w_cnt_n   = dut_outp;
        w_csum_n  = w_x;
        w_state_n = PAYLOAD;
      end
      PAYLOAD: if (!outp_valid) begin
        w_status = 1'b1;
        w_err[ERR_TRUNC] = 1'b1;
        w_state_n = IDLE;
      end else if (w_full) begin
        w_status = 1'b1;
        w_err[ERR_OVF] = 1'b1;
        w_state_n = DRAIN;
      end else begin
        w_wr      = 1'b1;
        w_cnt_n   = r_cnt - 8'd1;
        w_csum_n  = w_x;
        w_state_n = (r_cnt == 8'd1) ? CSUM : PAYLOAD;
      end
      CSUM: begin
        w_status  = 1'b1;
        w_state_n = IDLE;
        w_err[ERR_TRUNC] = !outp_valid;
        w_err[ERR_CSUM]  = outp_valid && (dut_outp != r_csum);
        w_commit  = outp_valid && (dut_outp == r_csum);
      end
      DRAIN: w_state_n = outp_valid ? DRAIN : IDLE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_da         <= '0;
      r_sa         <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_csum       <= '0;
      status_valid <= 1'b0;
      status_err   <= '0;
      hdr_da       <= '0;
      hdr_sa       <= '0;
      hdr_len      <= '0;
      pkt_count    <= '0;
      err_count    <= '0;
      pkt_valid    <= 1'b0;
      pkt_data     <= '0;
      pkt_last     <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_da         <= w_da_n;
      r_sa         <= w_sa_n;
      r_len        <= w_len_n;
      r_cnt        <= w_cnt_n;
      r_csum       <= w_csum_n;
      status_valid <= w_status;
      if (w_status) begin
        status_err <= w_err;
        hdr_da     <= w_da_n;
        hdr_sa     <= w_sa_n;
        hdr_len    <= w_len_n;
        if (|w_err) begin
          if (!(&err_count)) err_count <= err_count + 1'b1;
        end else if (!(&pkt_count)) pkt_count <= pkt_count + 1'b1;
      end
      // Output register holds its byte until the consumer takes it.
      if (w_rd_en) begin
        pkt_valid <= 1'b1;
        {pkt_last, pkt_data} <= w_rd_data;
      end else if (pkt_ready) pkt_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_router_pkt_receiver.sv
// tb_router_pkt_receiver: directed scenarios for the packet receiver with a small FIFO.
module tb_router_pkt_receiver;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  dut_outp = '0;
  logic        outp_valid = 1'b0;
  logic        pkt_ready = 1'b1;
  logic [7:0]  pkt_data, hdr_da, hdr_sa, hdr_len;
  logic        pkt_valid, pkt_last, status_valid, fifo_full;
  logic [3:0]  status_err;
  logic [15:0] pkt_count, err_count;
  int          tests = 0;
  int          failed = 0;
  int          n_status = 0;
  int          n0;
  logic [3:0]  last_err = '0;
  logic [8:0]  q[$];
  logic [7:0]  tx[$];
  logic [8:0]  got;

  router_pkt_receiver #(.DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .dut_outp(dut_outp), .outp_valid(outp_valid),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_last(pkt_last), .pkt_ready(pkt_ready),
    .hdr_da(hdr_da), .hdr_sa(hdr_sa), .hdr_len(hdr_len), .status_valid(status_valid),
    .status_err(status_err), .pkt_count(pkt_count), .err_count(err_count), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (status_valid) begin
      n_status++;
      last_err = status_err;
    end
    if (pkt_valid && pkt_ready) q.push_back({pkt_last, pkt_data});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send();
    foreach (tx[i]) begin
      dut_outp = tx[i];
      outp_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    outp_valid = 1'b0;
    dut_outp = '0;
  endtask

  task automatic test_reset();
    idle(2);
    tests++; if (pkt_valid !== 1'b0) begin failed++; $display("FAIL rst_pkt_valid got %b want 0", pkt_valid); end
    tests++; if (status_valid !== 1'b0) begin failed++; $display("FAIL rst_status_valid got %b want 0", status_valid); end
    tests++; if ({pkt_count, err_count} !== 32'd0) begin failed++; $display("FAIL rst_counts got %h want 0", {pkt_count, err_count}); end
    tests++; if ({hdr_da, hdr_sa, hdr_len, pkt_data, fifo_full} !== 33'd0) begin failed++; $display("FAIL rst_outs got %h want 0", {hdr_da, hdr_sa, hdr_len, pkt_data, fifo_full}); end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_good();
    logic [8:0] exp [3] = '{9'h0AA, 9'h0BB, 9'h1CC};
    q.delete();
    n0 = n_status;
    tx = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send();
    idle(6);
    tests++; if (n_status !== n0 + 1) begin failed++; $display("FAIL good_nstatus got %0d want %0d", n_status - n0, 1); end
    tests++; if (last_err !== 4'b0000) begin failed++; $display("FAIL good_err got %b want 0000", last_err); end
    tests++; if ({hdr_da, hdr_sa, hdr_len} !== 24'h010203) begin failed++; $display("FAIL good_hdr got %h want 010203", {hdr_da, hdr_sa, hdr_len}); end
    tests++; if (q.size() !== 3) begin failed++; $display("FAIL good_nbytes got %0d want 3", q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < q.size()) ? q[i] : 9'h1FF;
      tests++; if (got !== exp[i]) begin failed++; $display("FAIL good_byte%0d got %h want %h", i, got, exp[i]); end
    end
    tests++; if (pkt_count !== 16'd1) begin failed++; $display("FAIL good_pkt_count got %0d want 1", pkt_count); end
  endtask

  task automatic test_bad_csum();
    q.delete();
    tx = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    send();
    idle(6);
    tests++; if (last_err !== 4'b0001) begin failed++; $display("FAIL csum_err got %b want 0001", last_err); end
    tests++; if (q.size() !== 0 || pkt_valid !== 1'b0) begin failed++; $display("FAIL csum_out got %0d bytes want 0", q.size()); end
    tests++; if (err_count !== 16'd1) begin failed++; $display("FAIL csum_err_count got %0d want 1", err_count); end
  endtask

  task automatic test_trunc();
    logic [8:0] exp [3] = '{9'h0AA, 9'h0BB, 9'h1CC};
    q.delete();
    tx = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB};
    send();
    idle(4);
    tests++; if (last_err !== 4'b0010) begin failed++; $display("FAIL trunc_err got %b want 0010", last_err); end
    tests++; if (err_count !== 16'd2) begin failed++; $display("FAIL trunc_err_count got %0d want 2", err_count); end
    tx = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send();
    idle(6);
    tests++; if (q.size() !== 3) begin failed++; $display("FAIL trunc_next_nbytes got %0d want 3", q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < q.size()) ? q[i] : 9'h1FF;
      tests++; if (got !== exp[i]) begin failed++; $display("FAIL trunc_next_byte%0d got %h want %h", i, got, exp[i]); end
    end
    tests++; if (pkt_count !== 16'd2) begin failed++; $display("FAIL trunc_pkt_count got %0d want 2", pkt_count); end
  endtask

  task automatic test_len0();
    n0 = n_status;
    tx = '{8'h05, 8'h06, 8'h00, 8'h11, 8'h22};
    send();
    idle(4);
    tests++; if (n_status !== n0 + 1) begin failed++; $display("FAIL len0_nstatus got %0d want 1", n_status - n0); end
    tests++; if (last_err !== 4'b0100) begin failed++; $display("FAIL len0_err got %b want 0100", last_err); end
    tests++; if ({hdr_da, hdr_sa, hdr_len} !== 24'h050600) begin failed++; $display("FAIL len0_hdr got %h want 050600", {hdr_da, hdr_sa, hdr_len}); end
    tests++; if (err_count !== 16'd3) begin failed++; $display("FAIL len0_err_count got %0d want 3", err_count); end
  endtask

  task automatic ovf_pkt(input int at, input string tag);
    tx = '{8'h07, 8'h08, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h55};
    for (int i = 0; i < tx.size(); i++) begin
      dut_outp = tx[i];
      outp_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == at - 1) begin
        tests++; if (status_valid !== 1'b0 || fifo_full !== 1'b1) begin failed++; $display("FAIL %s_before got sv=%b full=%b want 0 1", tag, status_valid, fifo_full); end
      end
      if (i == at) begin
        tests++; if (status_valid !== 1'b1 || status_err !== 4'b1000) begin failed++; $display("FAIL %s_at got sv=%b err=%b want 1 1000", tag, status_valid, status_err); end
      end
    end
    outp_valid = 1'b0;
    dut_outp = '0;
    idle(3);
    tests++; if (fifo_full !== 1'b0 || hdr_len !== 8'h0A) begin failed++; $display("FAIL %s_after got full=%b len=%h want 0 0a", tag, fifo_full, hdr_len); end
  endtask

  task automatic test_overflow();
    logic [8:0] exp [3] = '{9'h0AA, 9'h0BB, 9'h1CC};
    q.delete();
    ovf_pkt(11, "ovf_empty");
    tests++; if (err_count !== 16'd4 || q.size() !== 0) begin failed++; $display("FAIL ovf_empty_cnt got %0d/%0d want 4/0", err_count, q.size()); end
    pkt_ready = 1'b0;
    tx = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send();
    idle(2);
    ovf_pkt(9, "ovf_held");
    pkt_ready = 1'b1;
    idle(6);
    tests++; if (q.size() !== 3) begin failed++; $display("FAIL ovf_held_nbytes got %0d want 3", q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < q.size()) ? q[i] : 9'h1FF;
      tests++; if (got !== exp[i]) begin failed++; $display("FAIL ovf_held_byte%0d got %h want %h", i, got, exp[i]); end
    end
    tests++; if ({pkt_count, err_count} !== {16'd3, 16'd5}) begin failed++; $display("FAIL ovf_counts got %0d/%0d want 3/5", pkt_count, err_count); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp [5] = '{9'h0AA, 9'h0BB, 9'h1CC, 9'h055, 9'h166};
    q.delete();
    pkt_ready = 1'b0;
    tx = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h09, 8'h0A, 8'h02, 8'h55, 8'h66, 8'h32};
    send();
    idle(4);
    tests++; if (pkt_valid !== 1'b1 || pkt_data !== 8'hAA) begin failed++; $display("FAIL bp_hold got v=%b d=%h want 1 aa", pkt_valid, pkt_data); end
    idle(3);
    tests++; if (pkt_valid !== 1'b1 || pkt_data !== 8'hAA || q.size() !== 0) begin failed++; $display("FAIL bp_stable got v=%b d=%h want 1 aa", pkt_valid, pkt_data); end
    pkt_ready = 1'b1;
    idle(10);
    tests++; if (q.size() !== 5) begin failed++; $display("FAIL bp_nbytes got %0d want 5", q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < q.size()) ? q[i] : 9'h1FF;
      tests++; if (got !== exp[i]) begin failed++; $display("FAIL bp_byte%0d got %h want %h", i, got, exp[i]); end
    end
    tests++; if (pkt_count !== 16'd5 || hdr_da !== 8'h09) begin failed++; $display("FAIL bp_count got %0d da=%h want 5 09", pkt_count, hdr_da); end
  endtask

  task automatic test_reset_mid();
    tx = '{8'h01, 8'h02, 8'h03, 8'hAA};
    foreach (tx[i]) begin
      dut_outp = tx[i];
      outp_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    tests++; if ({pkt_count, err_count} !== 32'd0) begin failed++; $display("FAIL mid_rst_counts got %h want 0", {pkt_count, err_count}); end
    tests++; if ({hdr_da, hdr_sa, hdr_len, status_err, status_valid, pkt_valid, pkt_last, pkt_data} !== 44'd0) begin failed++; $display("FAIL mid_rst_outs got %h want 0", {hdr_da, hdr_sa, hdr_len, status_err, status_valid, pkt_valid, pkt_last, pkt_data}); end
    outp_valid = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(2);
    q.delete();
    tx = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send();
    idle(6);
    tests++; if (q.size() !== 3 || pkt_count !== 16'd1) begin failed++; $display("FAIL mid_rst_after got %0d bytes cnt %0d want 3 1", q.size(), pkt_count); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_csum();
    test_trunc();
    test_len0();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
